// File: rtl/bit_scan_pkg.sv
// bit_scan_pkg: FSM state type and default index width shared by the bit_scan_encoder files
package bit_scan_pkg;
    localparam int DEFAULT_N = 4;
    typedef enum logic {IDLE, SCAN} state_t;
endpackage

// File: rtl/lsb_find.sv
// lsb_find: lowest-set-bit index and single-bit-set detect over a 2**N-bit vector
module lsb_find
    import bit_scan_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic [2**N-1:0] v,
    output logic [N-1:0]    idx,
    output logic            one
);
    always_comb begin
        idx = '0;
        for (int i = 2**N - 1; i >= 0; i--)
            if (v[i]) idx = i[N-1:0];
    end
    assign one = (v != '0) && ((v & (v - 1'b1)) == '0);
endmodule

// File: rtl/bit_scan_encoder.sv
// bit_scan_encoder: captures a request vector and emits its set-bit indices lowest first
// (sticky err_zero on accepted all-zero vectors when BIT_SCAN_ZERO_ERR_EN is defined)
module bit_scan_encoder
    import bit_scan_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           enable,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2**N-1:0] a,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [N-1:0]   y,
    output logic           last
`ifdef BIT_SCAN_ZERO_ERR_EN
    ,
    output logic           err_zero
`endif
);
    state_t          state;
    logic [2**N-1:0] pending;
    logic            one;
    logic            take;

    lsb_find #(.N(N)) u_find (.v(pending), .idx(y), .one(one));

    // pending is zero outside SCAN, so y and last read 0 in IDLE and reset
    assign in_ready  = rst_n && enable && state == IDLE;
    assign out_valid = state == SCAN;
    assign last      = out_valid && one;
    assign take      = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state   <= IDLE;
            pending <= '0;
        end else if (state == IDLE) begin
            if (take && a != '0) begin
                pending <= a;
                state   <= SCAN;
            end
        end else if (out_ready) begin
            pending <= pending & (pending - 1'b1);
            if (one) state <= IDLE;
        end

`ifdef BIT_SCAN_ZERO_ERR_EN
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) err_zero <= 1'b0;
        else if (take && a == '0) err_zero <= 1'b1;
`endif
endmodule

// File: tb/tb_bit_scan_encoder.sv
// tb_bit_scan_encoder: directed and random checks of bit_scan_encoder against a queue model
module tb_bit_scan_encoder;
    logic        clk = 1'b0;
    logic        rst_n, enable, in_valid, out_ready;
    logic [15:0] a;
    logic        in_ready, out_valid, last;
    logic [3:0]  y;
`ifdef BIT_SCAN_ZERO_ERR_EN
    logic        err_zero;
`endif
    int          q[$];
    bit          errz;
    int          n_cmp = 0;
    int          n_bad = 0;

    bit_scan_encoder #(.N(4)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .in_valid(in_valid),
        .in_ready(in_ready), .a(a), .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .last(last)
`ifdef BIT_SCAN_ZERO_ERR_EN
        , .err_zero(err_zero)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Drive one cycle at the negedge, check against the model, then advance the model
    task automatic cycle(input logic en, input logic iv, input logic [15:0] av, input logic ordy);
        enable = en; in_valid = iv; a = av; out_ready = ordy;
        #1;
        check("out_valid", 32'(out_valid), 32'(q.size() != 0));
        check("in_ready", 32'(in_ready), 32'(en && q.size() == 0));
        if (q.size() != 0) begin
            check("y", 32'(y), 32'(q[0]));
            check("last", 32'(last), 32'(q.size() == 1));
        end
`ifdef BIT_SCAN_ZERO_ERR_EN
        check("err_zero", 32'(err_zero), 32'(errz));
`endif
        if (q.size() == 0) begin
            if (en && iv) begin
                if (av == 16'h0) errz = 1'b1;
                else for (int i = 0; i < 16; i++) if (av[i]) q.push_back(i);
            end
        end else if (ordy) void'(q.pop_front());
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0; enable = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = 16'h0; errz = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_y", 32'(y), 32'd0);
        check("rst_last", 32'(last), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        // zero vector is dropped
        cycle(1, 1, 16'h0000, 1);
        repeat (2) cycle(1, 0, 16'h0, 1);
        // 0x0091 with out_ready high: 0,4,7 then idle
        cycle(1, 1, 16'h0091, 1);
        repeat (4) cycle(1, 0, 16'h0, 1);
        // all ones with out_ready toggling; new vectors offered mid-scan are ignored
        cycle(1, 1, 16'hFFFF, 1);
        for (int i = 0; i < 34; i++) cycle(1, 1, 16'($urandom), 1'(i % 2));
        repeat (2) cycle(1, 0, 16'h0, 1);
        // single top bit, enable dropped the next cycle
        cycle(1, 1, 16'h8000, 1);
        repeat (4) cycle(0, 1, 16'h0003, 1);
        cycle(1, 1, 16'h0003, 1);
        repeat (3) cycle(1, 0, 16'h0, 1);
        // reset after the y=5 handshake discards 6 and 7
        cycle(1, 1, 16'h00F0, 1);
        cycle(1, 0, 16'h0, 1);
        cycle(1, 0, 16'h0, 1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_out_valid", 32'(out_valid), 32'd0);
        check("rst_mid_in_ready", 32'(in_ready), 32'd0);
        check("rst_mid_y", 32'(y), 32'd0);
        check("rst_mid_last", 32'(last), 32'd0);
        q.delete();
        errz = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) cycle(1, 0, 16'h0, 1);
        // enable low holds off capture; raising it accepts that cycle
        repeat (5) cycle(0, 1, 16'h0102, 1);
        cycle(1, 1, 16'h0102, 0);
        repeat (4) cycle(1, 0, 16'h0, 1);
        // random traffic
        for (int i = 0; i < 400; i++) begin
            logic [15:0] v;
            v = ($urandom_range(0, 4) == 0) ? 16'h0 : 16'($urandom & $urandom & $urandom);
            cycle(1'($urandom_range(0, 3) != 0), 1'($urandom), v, 1'($urandom_range(0, 2) != 0));
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
